// File: rtl/obstacle_pkg.sv
// Shared types and constants for the obstacle scheduler and its renderer:
// select codes, sprite geometry, scheduler states and the spawn-type picker.
package obstacle_pkg;

  typedef enum logic [3:0] {
    SEL_NONE  = 4'b0000,
    SEL_CAC1S = 4'b0100,
    SEL_CAC1B = 4'b0101,
    SEL_CAC2S = 4'b0110,
    SEL_CAC2B = 4'b0111,
    SEL_BIRD  = 4'b1000
  } obstacle_sel_t;

  localparam int SCREEN_W    = 640;
  localparam int CAC1S_W     = 34;
  localparam int CAC2S_W     = 68;
  localparam int CAC1B_W     = 50;
  localparam int CAC2B_W     = 100;
  localparam int BIRD_W      = 92;
  localparam int SMALL_H     = 70;
  localparam int BIG_H       = 100;
  localparam int BIRD_H      = 80;
  localparam int BIRD_OFFSET = 70;

  localparam logic [1:0] GS_READY = 2'b00;
  localparam logic [1:0] GS_RUN   = 2'b01;
  localparam logic [1:0] GS_OVER  = 2'b10;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_GAP    = 2'd1;
  localparam logic [1:0] ST_ACTIVE = 2'd2;

  typedef struct packed {
    obstacle_sel_t sel;
    logic [9:0]    y;
  } spawn_t;

  // Three random bits pick the type; birds fall back to a small cactus when disabled.
  function automatic spawn_t pick_obstacle(input logic [2:0] c, input logic bird_en,
                                           input logic [9:0] y_small, input logic [9:0] y_big,
                                           input logic [9:0] y_bird);
    spawn_t s;
    s.sel = SEL_CAC1S;
    s.y   = y_small;
    case (c)
      3'd2:       s.sel = SEL_CAC2S;
      3'd3, 3'd4: begin s.sel = SEL_CAC1B; s.y = y_big; end
      3'd5:       begin s.sel = SEL_CAC2B; s.y = y_big; end
      3'd6, 3'd7: if (bird_en) begin s.sel = SEL_BIRD; s.y = y_bird; end
      default:    ;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/obstacle_lfsr.sv
// Free-running 16-bit Fibonacci LFSR (taps 16,14,13,11) used for obstacle
// type and gap randomisation.
module obstacle_lfsr #(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst,
  output logic [15:0] state
);

  // NOTE: sequential state is always written with non-blocking assignments.
  always_ff @(posedge clk) begin
    if (rst) state <= SEED;
    else     state <= {state[14:0], state[15] ^ state[13] ^ state[12] ^ state[10]};
  end

endmodule

// File: rtl/obstacle_scheduler.sv
// Single-slot obstacle sequencer: random spawn, per-frame scroll, retire at the
// left edge, random gap, and the bird wing-flap phase for the renderer.
module obstacle_scheduler
  import obstacle_pkg::*;
#(
  parameter int          SPAWN_X     = 640,
  parameter int          Y_SMALL     = 330,
  parameter int          Y_BIG       = 300,
  parameter int          Y_BIRD      = 200,
  parameter int          FIRST_GAP   = 30,
  parameter int          MIN_GAP     = 40,
  parameter int          FLAP_FRAMES = 8,
  parameter bit          BIRD_EN     = 1'b1,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] gamestate,
  input  logic       frame_tick,
  input  logic [3:0] speed,
  output logic [9:0] ObstacleX,
  output logic [9:0] ObstacleY,
  output logic [3:0] ObstacleSEL,
  output logic       BirdSEL,
  output logic       animateclk,
  output logic       obstacle_passed
);

  localparam logic [9:0] SPAWN_X_V   = 10'(SPAWN_X);
  localparam logic [9:0] Y_SMALL_V   = 10'(Y_SMALL);
  localparam logic [9:0] Y_BIG_V     = 10'(Y_BIG);
  localparam logic [9:0] Y_BIRD_V    = 10'(Y_BIRD);
  localparam logic [6:0] FIRST_GAP_V = 7'(FIRST_GAP);
  localparam logic [6:0] MIN_GAP_V   = 7'(MIN_GAP);
  localparam logic [7:0] FLAP_LAST   = 8'(FLAP_FRAMES - 1);

  logic [1:0]  state;
  logic [6:0]  gap_cnt;
  logic [7:0]  flap_cnt;
  logic [15:0] lfsr;
  logic [3:0]  spd;
  logic [9:0]  spd_x;
  logic        advance;
  spawn_t      pick;
  logic        lfsr_unused;

  obstacle_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
    .clk   (clk),
    .rst   (rst),
    .state (lfsr)
  );

  assign spd         = (speed == 4'd0) ? 4'd1 : speed;
  assign spd_x       = {6'd0, spd};
  assign advance     = frame_tick && (gamestate == GS_RUN);
  assign pick        = pick_obstacle(lfsr[2:0], BIRD_EN, Y_SMALL_V, Y_BIG_V, Y_BIRD_V);
  assign lfsr_unused = ^lfsr[15:6];

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= ST_IDLE;
      gap_cnt         <= '0;
      flap_cnt        <= '0;
      ObstacleX       <= SPAWN_X_V;
      ObstacleY       <= Y_SMALL_V;
      ObstacleSEL     <= SEL_NONE;
      BirdSEL         <= 1'b0;
      animateclk      <= 1'b0;
      obstacle_passed <= 1'b0;
    end else begin
      obstacle_passed <= 1'b0;
      if (state == ST_IDLE) begin
        if (gamestate == GS_RUN) begin
          gap_cnt <= FIRST_GAP_V;
          state   <= ST_GAP;
        end
      end else if (gamestate == GS_READY) begin
        // Restart: back to the reset picture, but the LFSR keeps running.
        state       <= ST_IDLE;
        gap_cnt     <= '0;
        flap_cnt    <= '0;
        ObstacleX   <= SPAWN_X_V;
        ObstacleY   <= Y_SMALL_V;
        ObstacleSEL <= SEL_NONE;
        BirdSEL     <= 1'b0;
        animateclk  <= 1'b0;
      end else if (advance) begin
        if (flap_cnt == FLAP_LAST) begin
          flap_cnt   <= '0;
          animateclk <= ~animateclk;
        end else begin
          flap_cnt <= flap_cnt + 8'd1;
        end
        if (state == ST_ACTIVE) begin
          // Retiring when X < spd means X never wraps below zero.
          if (ObstacleX < spd_x) begin
            obstacle_passed <= 1'b1;
            ObstacleSEL     <= SEL_NONE;
            BirdSEL         <= 1'b0;
            ObstacleX       <= SPAWN_X_V;
            gap_cnt         <= MIN_GAP_V + {1'b0, lfsr[5:0]};
            state           <= ST_GAP;
          end else begin
            ObstacleX <= ObstacleX - spd_x;
          end
        end else if (gap_cnt == 7'd0) begin
          ObstacleSEL <= pick.sel;
          ObstacleY   <= pick.y;
          BirdSEL     <= (pick.sel == SEL_BIRD);
          ObstacleX   <= SPAWN_X_V;
          state       <= ST_ACTIVE;
        end else begin
          gap_cnt <= gap_cnt - 7'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_obstacle_scheduler.sv
// Directed bench for obstacle_scheduler: a behavioural model feeds a scoreboard
// of expected outputs, plus a second instance with birds disabled.
module tb_obstacle_scheduler;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] gamestate;
  logic       frame_tick;
  logic [3:0] speed;
  logic [9:0] ObstacleX, ObstacleY;
  logic [3:0] ObstacleSEL;
  logic       BirdSEL, animateclk, obstacle_passed;

  logic [1:0] gs2;
  logic [3:0] speed2;
  logic [9:0] x2, y2;
  logic [3:0] sel2;
  logic       bird2, anim2, passed2;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  obstacle_scheduler dut (
    .clk(clk), .rst(rst), .gamestate(gamestate), .frame_tick(frame_tick), .speed(speed),
    .ObstacleX(ObstacleX), .ObstacleY(ObstacleY), .ObstacleSEL(ObstacleSEL),
    .BirdSEL(BirdSEL), .animateclk(animateclk), .obstacle_passed(obstacle_passed)
  );

  obstacle_scheduler #(.BIRD_EN(1'b0)) dut_nb (
    .clk(clk), .rst(rst), .gamestate(gs2), .frame_tick(frame_tick), .speed(speed2),
    .ObstacleX(x2), .ObstacleY(y2), .ObstacleSEL(sel2),
    .BirdSEL(bird2), .animateclk(anim2), .obstacle_passed(passed2)
  );

  // Reference LFSR: 16-bit Fibonacci, taps 16,14,13,11, seed ACE1.
  logic [15:0] m_lfsr;
  always @(posedge clk) begin
    if (rst) m_lfsr <= 16'hACE1;
    else     m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
  end

  typedef enum {M_IDLE, M_GAP, M_ACTIVE} mstate_t;
  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic [3:0] sel;
    logic       bird;
    logic       anim;
    logic       passed;
  } exp_t;

  exp_t       sb[$];
  mstate_t    m_state;
  int         m_gap, m_flap;
  logic [9:0] m_x, m_y;
  logic [3:0] m_sel;
  logic       m_bird, m_anim, m_passed;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  function automatic logic [9:0] y_for(input logic [3:0] s);
    case (s)
      4'b0100, 4'b0110: return 10'd330;
      4'b0101, 4'b0111: return 10'd300;
      4'b1000:          return 10'd200;
      default:          return 10'h3FF;
    endcase
  endfunction

  task automatic model_clear_outputs();
    m_x = 10'd640; m_y = 10'd330; m_sel = 4'b0000; m_bird = 1'b0;
    m_anim = 1'b0; m_flap = 0; m_gap = 0;
  endtask

  // Expected outputs after the coming clock edge, given the inputs now applied.
  task automatic model_update(input logic t);
    int s;
    m_passed = 1'b0;
    s = (speed == 4'd0) ? 1 : int'(speed);
    if (rst) begin
      model_clear_outputs();
      m_state = M_IDLE;
    end else if (m_state == M_IDLE) begin
      if (gamestate == 2'b01) begin m_gap = 30; m_state = M_GAP; end
    end else if (gamestate == 2'b00) begin
      model_clear_outputs();
      m_state = M_IDLE;
    end else if (gamestate == 2'b01 && t) begin
      m_flap = m_flap + 1;
      if (m_flap == 8) begin m_flap = 0; m_anim = ~m_anim; end
      if (m_state == M_GAP) begin
        if (m_gap > 0) m_gap = m_gap - 1;
        else begin
          case (m_lfsr[2:0])
            3'd0, 3'd1: m_sel = 4'b0100;
            3'd2:       m_sel = 4'b0110;
            3'd3, 3'd4: m_sel = 4'b0101;
            3'd5:       m_sel = 4'b0111;
            default:    m_sel = 4'b1000;
          endcase
          m_y = y_for(m_sel);
          m_bird = (m_sel == 4'b1000);
          m_x = 10'd640;
          m_state = M_ACTIVE;
        end
      end else if (int'(m_x) >= s) begin
        m_x = m_x - 10'(s);
      end else begin
        m_passed = 1'b1;
        m_sel = 4'b0000; m_bird = 1'b0; m_x = 10'd640;
        m_gap = 40 + int'(m_lfsr[5:0]);
        m_state = M_GAP;
      end
    end
  endtask

  // One clock: apply inputs, push the prediction, then compare it after the edge.
  task automatic step(input logic t);
    exp_t e;
    frame_tick = t;
    model_update(t);
    sb.push_back({m_x, m_y, m_sel, m_bird, m_anim, m_passed});
    @(negedge clk);
    e = sb.pop_front();
    check("sb_x",    32'(ObstacleX),       32'(e.x));
    check("sb_y",    32'(ObstacleY),       32'(e.y));
    check("sb_sel",  32'(ObstacleSEL),     32'(e.sel));
    check("sb_bird", 32'(BirdSEL),         32'(e.bird));
    check("sb_anim", 32'(animateclk),      32'(e.anim));
    check("sb_pass", 32'(obstacle_passed), 32'(e.passed));
  endtask

  initial begin
    int n, exp_gap, bird_seen, last_tog, spawns2;
    logic [9:0] x_hold;
    logic [3:0] prev_sel, prev_sel2;
    logic prev_anim, anim_hold;

    rst = 1'b1; gamestate = 2'b00; frame_tick = 1'b0; speed = 4'd5;
    gs2 = 2'b00; speed2 = 4'd15;
    step(0); step(0);
    rst = 1'b0;
    check("rst_x", 32'(ObstacleX), 640);
    check("rst_sel", 32'(ObstacleSEL), 0);

    // First spawn lands on the 31st frame tick after the run starts.
    gamestate = 2'b01;
    step(0);
    n = 0;
    while (ObstacleSEL == 4'b0000 && n < 200) begin step(1); n++; end
    check("first_gap_ticks", 32'(n), 31);
    check("first_spawn_x", 32'(ObstacleX), 640);

    speed = 4'd5;
    repeat (10) step(1);
    check("scroll_spd5", 32'(ObstacleX), 590);
    speed = 4'd0;
    repeat (3) step(1);
    check("scroll_spd0", 32'(ObstacleX), 587);
    speed = 4'd1;
    repeat (2) step(1);
    speed = 4'd5;
    n = 0;
    while (ObstacleX != 10'd5 && n < 200) begin step(1); n++; end
    check("reach_x5", 32'(ObstacleX), 5);
    step(1);
    check("x_eq_spd_to_0", 32'(ObstacleX), 0);
    check("x_eq_spd_no_pass", 32'(obstacle_passed), 0);
    step(1);
    check("retire_pass", 32'(obstacle_passed), 1);
    check("retire_sel", 32'(ObstacleSEL), 0);
    check("retire_x", 32'(ObstacleX), 640);
    exp_gap = m_gap;
    step(0);
    check("pass_one_clk", 32'(obstacle_passed), 0);
    n = 0;
    while (ObstacleSEL == 4'b0000 && n < 200) begin step(1); n++; end
    check("gap_in_range", 32'((n - 1) >= 40 && (n - 1) <= 103), 1);
    check("gap_exact", 32'(n), 32'(exp_gap + 1));

    // Freeze with gamestate=10: nothing moves for 50 ticks.
    repeat (13) step(1);
    x_hold = m_x;
    anim_hold = m_anim;
    gamestate = 2'b10;
    repeat (50) step(1);
    check("freeze_x", 32'(ObstacleX), 32'(x_hold));
    check("freeze_anim", 32'(animateclk), 32'(anim_hold));

    gamestate = 2'b00;
    step(0);
    check("restart_x", 32'(ObstacleX), 640);
    check("restart_y", 32'(ObstacleY), 330);
    check("restart_sel", 32'(ObstacleSEL), 0);
    check("restart_anim", 32'(animateclk), 0);
    gamestate = 2'b01;
    step(0);
    n = 0;
    while (ObstacleSEL == 4'b0000 && n < 200) begin step(1); n++; end
    check("restart_gap_ticks", 32'(n), 31);

    // Run until birds appear; also measure the wing-flap period.
    speed = 4'd15;
    bird_seen = 0; last_tog = -1; n = 0;
    prev_sel = ObstacleSEL; prev_anim = animateclk;
    while (bird_seen < 2 && n < 20000) begin
      step(1); n++;
      if (ObstacleSEL == 4'b1000 && prev_sel == 4'b0000) begin
        bird_seen++;
        check("bird_y", 32'(ObstacleY), 200);
        check("bird_birdsel", 32'(BirdSEL), 1);
      end
      if (animateclk != prev_anim) begin
        if (last_tog >= 0) check("flap_period", 32'(n - last_tog), 8);
        last_tog = n;
      end
      prev_sel = ObstacleSEL; prev_anim = animateclk;
    end
    check("birds_seen", 32'(bird_seen >= 2), 1);

    // Birds disabled: every spawn must be a cactus with the matching Y.
    gamestate = 2'b00;
    step(0);
    gs2 = 2'b01;
    spawns2 = 0; n = 0; prev_sel2 = sel2;
    while (spawns2 < 150 && n < 30000) begin
      step(1); n++;
      if (sel2 != 4'b0000 && prev_sel2 == 4'b0000) begin
        spawns2++;
        check("nb_not_bird", 32'(sel2 != 4'b1000), 1);
        check("nb_y_matches", 32'(y2), 32'(y_for(sel2)));
        check("nb_birdsel", 32'(bird2), 0);
      end
      prev_sel2 = sel2;
    end
    check("nb_spawns", 32'(spawns2), 150);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
